// File: rtl/ram_tap_uart_tx.sv
// ---------------------------------------------------------------------------
// ram_tap_uart_tx
//
// Watches the processor's data-RAM write port and copies every write aimed
// at one tap address into a small FIFO. Each queued 16-bit word is sent on a
// UART 8N1 line as two bytes, high byte first, giving the board a debug or
// result channel without touching the processor or the RAM.
//
// Ports:
//   i_clock     processor clock, all state changes on the rising edge
//   i_reset     asynchronous active-low reset
//   i_Wr        RAM write strike, one write per cycle while high
//   i_Addr      RAM address
//   i_Data      RAM write data
//   o_tx        UART serial line, idles high, registered
//   o_busy      high while a frame is on the line or the FIFO holds words
//   o_overflow  sticky, set when a tap write was dropped on a full FIFO
//   o_count     number of words currently in the FIFO (0..depth)
// ---------------------------------------------------------------------------
module ram_tap_uart_tx #(
   parameter int                     DATA_LENGTH = 16,
   parameter int                     ADDR_LENGTH = 11,
   parameter logic [ADDR_LENGTH-1:0] TAP_ADDR    = 11'h7FF,
   parameter int                     BAUD_DIV    = 868,
   parameter int                     FIFO_AW     = 3
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_Wr,
   input  logic [ADDR_LENGTH-1:0] i_Addr,
   input  logic [DATA_LENGTH-1:0] i_Data,
   output logic                   o_tx,
   output logic                   o_busy,
   output logic                   o_overflow,
   output logic [FIFO_AW:0]       o_count
);

   localparam int                 DEPTH    = 1 << FIFO_AW;
   localparam int                 CW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0]      BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0]      BAUD_ONE  = 1;
   localparam logic [FIFO_AW:0]   DEPTH_C   = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } TxState;

   TxState                  r_state;
   TxState                  w_nextState;

   logic [DATA_LENGTH-1:0]  r_mem [DEPTH];
   logic [FIFO_AW-1:0]      r_wrPtr;
   logic [FIFO_AW-1:0]      r_rdPtr;
   logic [FIFO_AW:0]        r_count;
   logic                    r_overflow;

   logic [CW-1:0]           r_baudCnt;
   logic [2:0]              r_bitIdx;
   logic                    r_byteSel;
   logic [DATA_LENGTH-1:0]  r_word;
   logic                    r_tx;

   logic                    w_push;
   logic                    w_pushOk;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_baudDone;
   logic [CW-1:0]           w_baudNext;
   logic [2:0]              w_bitIdxNext;
   logic                    w_byteSelNext;
   logic [DATA_LENGTH-1:0]  w_wordNext;
   logic [7:0]              w_byteNext;
   logic                    w_txNext;

   // A tap write is accepted when there is room, or when the transmitter
   // frees a slot on the same edge so a full FIFO stays full.
   assign w_push     = i_Wr && (i_Addr == TAP_ADDR);
   assign w_full     = (r_count == DEPTH_C);
   assign w_pop      = (r_state == IDLE) && (r_count != '0);
   assign w_pushOk   = w_push && (!w_full || w_pop);
   assign w_baudDone = (r_baudCnt == BAUD_LAST);

   // FIFO storage has no reset; only the pointers and count define content.
   always_ff @(posedge i_clock) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr] <= i_Data;
      end
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         if (w_pushOk && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_pushOk) begin
            r_count <= r_count - CNT_ONE;
         end
         if (w_push && !w_pushOk) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Transmitter state register.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: each non-idle state lasts whole bit-times, and the
   // stop bit of the high byte leads straight into the low byte's start bit.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_nextState = START;
            end
         end
         START: begin
            if (w_baudDone) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            if (w_baudDone && (r_bitIdx == 3'd7)) begin
               w_nextState = STOP;
            end
         end
         STOP: begin
            if (w_baudDone) begin
               w_nextState = r_byteSel ? START : IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Output logic: computes the datapath values for the coming cycle so the
   // serial line can be registered and still change on the same edge as the
   // state it belongs to.
   always_comb begin
      w_baudNext    = r_baudCnt + BAUD_ONE;
      w_bitIdxNext  = r_bitIdx;
      w_byteSelNext = r_byteSel;
      w_wordNext    = r_word;
      w_txNext      = 1'b1;

      if ((r_state == IDLE) || (w_nextState != r_state) || w_baudDone) begin
         w_baudNext = '0;
      end

      if (r_state != DATA) begin
         w_bitIdxNext = 3'd0;
      end else if (w_baudDone) begin
         w_bitIdxNext = r_bitIdx + 3'd1;
      end

      if (w_pop) begin
         w_byteSelNext = 1'b1;
         w_wordNext    = r_mem[r_rdPtr];
      end else if ((r_state == STOP) && w_baudDone) begin
         w_byteSelNext = 1'b0;
      end

      w_byteNext = w_byteSelNext ? w_wordNext[DATA_LENGTH-1 -: 8] : w_wordNext[7:0];

      case (w_nextState)
         START:   w_txNext = 1'b0;
         DATA:    w_txNext = w_byteNext[w_bitIdxNext];
         default: w_txNext = 1'b1;
      endcase
   end

   // Transmitter datapath registers, including the glitch-free line driver.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_baudCnt <= '0;
         r_bitIdx  <= 3'd0;
         r_byteSel <= 1'b0;
         r_word    <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_baudCnt <= w_baudNext;
         r_bitIdx  <= w_bitIdxNext;
         r_byteSel <= w_byteSelNext;
         r_word    <= w_wordNext;
         r_tx      <= w_txNext;
      end
   end

   assign o_tx       = r_tx;
   assign o_busy     = (r_state != IDLE) || (r_count != '0);
   assign o_overflow = r_overflow;
   assign o_count    = r_count;

endmodule

// File: tb/tb_ram_tap_uart_tx.sv
module tb_ram_tap_uart_tx;

   localparam int          BAUD     = 4;
   localparam int          AW       = 11;
   localparam logic [10:0] TAP      = 11'h7FF;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_Wr    = 1'b0;
   logic [10:0] i_Addr  = '0;
   logic [15:0] i_Data  = '0;
   logic        o_tx;
   logic        o_busy;
   logic        o_overflow;
   logic [3:0]  o_count;

   int          testsRun  = 0;
   int          failCount = 0;
   logic [15:0] scoreboard[$];
   logic        monEnable = 1'b1;

   ram_tap_uart_tx #(
      .DATA_LENGTH (16),
      .ADDR_LENGTH (AW),
      .TAP_ADDR    (TAP),
      .BAUD_DIV    (BAUD),
      .FIFO_AW     (3)
   ) dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_Wr       (i_Wr),
      .i_Addr     (i_Addr),
      .i_Data     (i_Data),
      .o_tx       (o_tx),
      .o_busy     (o_busy),
      .o_overflow (o_overflow),
      .o_count    (o_count)
   );

   always #5 i_clock = ~i_clock;

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one bus cycle just after a falling edge, let the rising edge take
   // it, then drop the strike. Accepted tap words go to the scoreboard.
   task automatic applyStimulus(input logic wr, input logic [10:0] addr,
                                input logic [15:0] data, input logic expectSent);
      @(negedge i_clock);
      i_Wr   = wr;
      i_Addr = addr;
      i_Data = data;
      if (expectSent) scoreboard.push_back(data);
      @(posedge i_clock);
      #1;
      i_Wr = 1'b0;
   endtask

   task automatic applyReset();
      i_reset = 1'b0;
      repeat (3) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
      #1;
   endtask

   // Counts rising edges until o_busy falls, giving up after 'bound'.
   task automatic waitIdle(input int bound, output int cycles);
      cycles = 0;
      while (o_busy && cycles < bound) begin
         @(posedge i_clock);
         #1;
         cycles++;
      end
   endtask

   // UART receiver: samples mid-bit on falling edges, pairs bytes into words
   // (high byte first) and pops the scoreboard for each complete word.
   int          rxCnt    = 0;
   logic        rxActive = 1'b0;
   logic        haveHigh = 1'b0;
   logic [7:0]  rxByte   = '0;
   logic [7:0]  rxHigh   = '0;

   always @(negedge i_clock) begin
      if (!monEnable || !i_reset) begin
         rxActive = 1'b0;
         haveHigh = 1'b0;
         rxCnt    = 0;
      end else if (!rxActive) begin
         if (o_tx === 1'b0) begin
            rxActive = 1'b1;
            rxCnt    = 0;
         end
      end else begin
         rxCnt++;
         if (rxCnt == BAUD / 2) begin
            checkOutput("startBit", {31'd0, o_tx}, 32'd0);
         end
         for (int j = 0; j < 8; j++) begin
            if (rxCnt == BAUD * (j + 1) + BAUD / 2) rxByte[j] = o_tx;
         end
         if (rxCnt == BAUD * 9 + BAUD / 2) begin
            checkOutput("stopBit", {31'd0, o_tx}, 32'd1);
            rxActive = 1'b0;
            if (!haveHigh) begin
               rxHigh   = rxByte;
               haveHigh = 1'b1;
            end else begin
               haveHigh = 1'b0;
               checkOutput("wordExpected", {31'd0, scoreboard.size() != 0}, 32'd1);
               if (scoreboard.size() != 0) begin
                  checkOutput("rxWord", {16'd0, rxHigh, rxByte},
                              {16'd0, scoreboard.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   n;
      int   maxCount;
      logic sawLow;

      // Reset state
      applyReset();
      checkOutput("resetTx",       {31'd0, o_tx},       32'd1);
      checkOutput("resetBusy",     {31'd0, o_busy},     32'd0);
      checkOutput("resetOverflow", {31'd0, o_overflow}, 32'd0);
      checkOutput("resetCount",    {28'd0, o_count},    32'd0);

      // Single word: count after capture edge, line falls one edge later
      applyStimulus(1'b1, TAP, 16'hA55A, 1'b1);
      checkOutput("singleCount1", {28'd0, o_count}, 32'd1);
      checkOutput("singleTxHigh", {31'd0, o_tx},    32'd1);
      @(posedge i_clock);
      #1;
      checkOutput("singleTxFall", {31'd0, o_tx},    32'd0);
      checkOutput("singleCount0", {28'd0, o_count}, 32'd0);
      checkOutput("singleBusy",   {31'd0, o_busy},  32'd1);
      waitIdle(200, n);
      checkOutput("singleFrameLen", n, 32'd80);
      checkOutput("singleSbEmpty", scoreboard.size(), 32'd0);

      // Address filter
      applyStimulus(1'b1, TAP - 11'd1, 16'h1234, 1'b0);
      checkOutput("filterAddrCount", {28'd0, o_count}, 32'd0);
      checkOutput("filterAddrTx",    {31'd0, o_tx},    32'd1);
      applyStimulus(1'b0, TAP, 16'hFFFF, 1'b0);
      checkOutput("filterWrCount", {28'd0, o_count}, 32'd0);
      checkOutput("filterWrTx",    {31'd0, o_tx},    32'd1);
      repeat (10) @(posedge i_clock);
      #1;
      checkOutput("filterIdleBusy", {31'd0, o_busy}, 32'd0);

      // Overflow: ten back-to-back tap writes, the tenth is dropped
      for (int v = 1; v <= 10; v++) begin
         applyStimulus(1'b1, TAP, 16'(v), v <= 9);
         if (v == 9) checkOutput("ovfNotYet", {31'd0, o_overflow}, 32'd0);
      end
      checkOutput("ovfFlag",  {31'd0, o_overflow}, 32'd1);
      checkOutput("ovfCount", {28'd0, o_count},    32'd8);
      waitIdle(2000, n);
      checkOutput("ovfDrained",  {31'd0, o_busy},  32'd0);
      checkOutput("ovfSbEmpty",  scoreboard.size(), 32'd0);
      checkOutput("ovfSticky",   {31'd0, o_overflow}, 32'd1);
      applyReset();
      checkOutput("ovfCleared",  {31'd0, o_overflow}, 32'd0);

      // Wrap: twenty words spaced 85 cycles apart
      maxCount = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, TAP, 16'(i * 16'h1357) ^ 16'hC3A5, 1'b1);
         if (int'(o_count) > maxCount) maxCount = int'(o_count);
         repeat (84) begin
            @(posedge i_clock);
            #1;
            if (int'(o_count) > maxCount) maxCount = int'(o_count);
         end
      end
      waitIdle(2000, n);
      checkOutput("wrapDrained",  {31'd0, o_busy},   32'd0);
      checkOutput("wrapSbEmpty",  scoreboard.size(), 32'd0);
      checkOutput("wrapMaxCount", {31'd0, maxCount <= 2}, 32'd1);

      // Reset during data bit 3 of the high byte, with a second word queued
      monEnable = 1'b0;
      applyStimulus(1'b1, TAP, 16'h0000, 1'b0);
      applyStimulus(1'b1, TAP, 16'h1111, 1'b0);
      repeat (17) @(posedge i_clock);
      #1;
      checkOutput("midBit3Low",  {31'd0, o_tx},    32'd0);
      checkOutput("midQueued",   {28'd0, o_count}, 32'd1);
      i_reset = 1'b0;
      #1;
      checkOutput("midResetTx",    {31'd0, o_tx},    32'd1);
      checkOutput("midResetCount", {28'd0, o_count}, 32'd0);
      checkOutput("midResetBusy",  {31'd0, o_busy},  32'd0);
      repeat (2) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
      sawLow  = 1'b0;
      repeat (200) begin
         @(negedge i_clock);
         if (o_tx !== 1'b1) sawLow = 1'b1;
      end
      checkOutput("midNoResidual", {31'd0, sawLow}, 32'd0);
      checkOutput("midIdleBusy",   {31'd0, o_busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
